// File: rtl/multicycle_sequencer_legv8.sv
// multicycle_sequencer_legv8: multi-cycle LEGv8 control sequencer (FETCH/EX0/EX1/MEMWAIT/HALT).
// Latency: 1-cycle ops 2 cycles incl. fetch, MOV 3, memory 2 + MEMWAIT cycles; retire pulses in last execute cycle.
// Backpressure: FETCH waits indefinitely for instr_valid; MEMWAIT waits for mem_ready up to MEM_TIMEOUT cycles.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   I, instr_valid          instruction word from imem and its valid (sampled only in FETCH)
//   mem_ready               dmem completes the current access this cycle
//   status                  {V,C,N,Z,Zraw}, informational only
//   state                   current state encoding
//   il/rw/mw/sl/mem_req     datapath strobes (combinational from state, IR and handshakes)
//   const_sel               constant-generator select
//   retire, retired_count   completion pulse and wrapping completion count
//   illegal/bus_err/halted  sticky fault/halt flags
module multicycle_sequencer_legv8 #(
    parameter int INSTR_W     = 32,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] I,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic [4:0]         status,
    output logic [2:0]         state,
    output logic               il,
    output logic               rw,
    output logic               mw,
    output logic               sl,
    output logic               mem_req,
    output logic [2:0]         const_sel,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_count,
    output logic               illegal,
    output logic               bus_err,
    output logic               halted
);

    localparam logic [2:0] LP_FETCH   = 3'd0;
    localparam logic [2:0] LP_EX0     = 3'd1;
    localparam logic [2:0] LP_EX1     = 3'd2;
    localparam logic [2:0] LP_MEMWAIT = 3'd4;
    localparam logic [2:0] LP_HALT    = 3'd7;

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] LP_WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_illegal;
    logic               r_bus_err;
    logic               r_halted;

    logic [2:0] w_nxt;
    logic       w_il;
    logic       w_rw;
    logic       w_mw;
    logic       w_sl;
    logic       w_mreq;
    logic [2:0] w_cs;
    logic       w_ret;
    logic       w_set_ill;
    logic       w_set_be;

    // Instruction class: 0 DataImm, 1 Branch, 2 Mem, 3 DataReg.
    logic [1:0] w_class;
    logic       w_sl_logic;
    logic       w_mem_ok;
    logic       w_timeout;
    logic       w_unused;

    assign w_class    = {r_ir[27], (~r_ir[27] & r_ir[26]) | (r_ir[27] & r_ir[25])};
    assign w_sl_logic = (r_ir[30:29] == 2'b11);
    // Only plain LDUR/STUR are supported in the memory class.
    assign w_mem_ok   = ({r_ir[29], r_ir[28], r_ir[24], r_ir[21], r_ir[11], r_ir[10]} == 6'b110000);
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait == LP_WAIT_LAST);
    assign w_unused   = ^{status, r_ir[20:12], r_ir[9:0]};

    always_comb begin
        w_nxt     = r_state;
        w_il      = 1'b0;
        w_rw      = 1'b0;
        w_mw      = 1'b0;
        w_sl      = 1'b0;
        w_mreq    = 1'b0;
        w_cs      = 3'd0;
        w_ret     = 1'b0;
        w_set_ill = 1'b0;
        w_set_be  = 1'b0;
        case (r_state)
            LP_FETCH: begin
                w_il = instr_valid;
                if (instr_valid) w_nxt = LP_EX0;
            end
            LP_EX0: begin
                case (w_class)
                    2'd0: begin
                        case (r_ir[25:23])
                            3'b010: begin
                                w_rw  = 1'b1;
                                w_sl  = r_ir[29];
                                w_ret = 1'b1;
                                w_nxt = LP_FETCH;
                            end
                            3'b100: begin
                                w_rw  = 1'b1;
                                w_sl  = w_sl_logic;
                                w_ret = 1'b1;
                                w_nxt = LP_FETCH;
                            end
                            3'b101: begin
                                w_rw  = 1'b1;
                                w_cs  = 3'd2;
                                w_nxt = LP_EX1;
                            end
                            default: begin
                                w_set_ill = 1'b1;
                                w_nxt     = LP_HALT;
                            end
                        endcase
                    end
                    2'd1: begin
                        w_cs  = (r_ir[30:29] == 2'b00) ? 3'd4 : 3'd5;
                        // Only BL writes the link register.
                        w_rw  = r_ir[31] & (r_ir[30:29] == 2'b00);
                        w_ret = 1'b1;
                        w_nxt = LP_FETCH;
                    end
                    2'd2: begin
                        if (w_mem_ok) begin
                            w_mreq = 1'b1;
                            w_cs   = 3'd6;
                            if (mem_ready) begin
                                w_rw  = r_ir[22];
                                w_mw  = ~r_ir[22];
                                w_ret = 1'b1;
                                w_nxt = LP_FETCH;
                            end else begin
                                w_nxt = LP_MEMWAIT;
                            end
                        end else begin
                            w_set_ill = 1'b1;
                            w_nxt     = LP_HALT;
                        end
                    end
                    default: begin
                        if (!r_ir[28]) begin
                            w_rw  = 1'b1;
                            w_sl  = r_ir[24] ? r_ir[29] : w_sl_logic;
                            w_ret = 1'b1;
                            w_nxt = LP_FETCH;
                        end else begin
                            w_set_ill = 1'b1;
                            w_nxt     = LP_HALT;
                        end
                    end
                endcase
            end
            LP_EX1: begin
                w_rw  = 1'b1;
                w_cs  = 3'd3;
                w_ret = 1'b1;
                w_nxt = LP_FETCH;
            end
            LP_MEMWAIT: begin
                // Address constant stays selected while the access is outstanding.
                w_mreq = 1'b1;
                w_cs   = 3'd6;
                if (mem_ready) begin
                    w_rw  = r_ir[22];
                    w_mw  = ~r_ir[22];
                    w_ret = 1'b1;
                    w_nxt = LP_FETCH;
                end else if (w_timeout) begin
                    w_set_be = 1'b1;
                    w_nxt    = LP_HALT;
                end
            end
            LP_HALT: begin
                w_nxt = LP_HALT;
            end
            default: begin
                // Unused encodings fall back to fetch.
                w_nxt = LP_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= LP_FETCH;
            r_ir      <= '0;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if ((r_state == LP_FETCH) && instr_valid) r_ir <= I;
            // Counter is parked at zero outside MEMWAIT so it starts from zero on entry.
            if (r_state != LP_MEMWAIT) r_wait <= '0;
            else if (!mem_ready)        r_wait <= r_wait + WAIT_W'(1);
            if (w_ret)     r_cnt     <= r_cnt + CNT_W'(1);
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_be)  r_bus_err <= 1'b1;
            if (w_nxt == LP_HALT) r_halted <= 1'b1;
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    assign state         = r_state;
    assign il            = w_il   & ~reset;
    assign rw            = w_rw   & ~reset;
    assign mw            = w_mw   & ~reset;
    assign sl            = w_sl   & ~reset;
    assign mem_req       = w_mreq & ~reset;
    assign const_sel     = reset ? 3'd0 : w_cs;
    assign retire        = w_ret  & ~reset;
    assign retired_count = r_cnt;
    assign illegal       = r_illegal;
    assign bus_err       = r_bus_err;
    assign halted        = r_halted;

endmodule

// File: tb/tb_multicycle_sequencer_legv8.sv
// tb_multicycle_sequencer_legv8: per-cycle scoreboard bench for the LEGv8 sequencer.
// Expected output vectors are queued with each stimulus cycle and compared after the run.
// Observed vector = {state, il, rw, mw, sl, mem_req, const_sel, retire, illegal, bus_err, halted}.
module tb_multicycle_sequencer_legv8;

    localparam int TB_CNT_W = 4;

    localparam logic [31:0] ADDI  = 32'h91001441;
    localparam logic [31:0] MOVZ  = 32'hD2800000;
    localparam logic [31:0] LDUR  = 32'hF8400000;
    localparam logic [31:0] STUR  = 32'hF8000000;

    logic                clock;
    logic                reset;
    logic [31:0]         I;
    logic                instr_valid;
    logic                mem_ready;
    logic [4:0]          status;
    logic [2:0]          state;
    logic                il, rw, mw, sl, mem_req;
    logic [2:0]          const_sel;
    logic                retire;
    logic [TB_CNT_W-1:0] retired_count;
    logic                illegal, bus_err, halted;

    int                  n_pass  = 0;
    int                  n_total = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;
    logic [14:0]         exp_q[$];
    logic [14:0]         got_q[$];

    multicycle_sequencer_legv8 #(
        .INSTR_W(32), .CNT_W(TB_CNT_W), .MEM_TIMEOUT(15)
    ) dut (
        .clock(clock), .reset(reset), .I(I), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .status(status), .state(state), .il(il), .rw(rw),
        .mw(mw), .sl(sl), .mem_req(mem_req), .const_sel(const_sel), .retire(retire),
        .retired_count(retired_count), .illegal(illegal), .bus_err(bus_err), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [14:0] obs();
        return {state, il, rw, mw, sl, mem_req, const_sel, retire, illegal, bus_err, halted};
    endfunction

    function automatic logic [14:0] e(input logic [2:0] st, input logic l, input logic w,
                                      input logic m, input logic s, input logic q,
                                      input logic [2:0] cs, input logic rt, input logic ill,
                                      input logic be, input logic hl);
        return {st, l, w, m, s, q, cs, rt, ill, be, hl};
    endfunction

    // One clock cycle of stimulus; outputs sampled 1 unit after the falling edge.
    task automatic cyc(input logic [31:0] ins, input logic iv, input logic mr);
        @(negedge clock);
        I = ins; instr_valid = iv; mem_ready = mr;
        #1;
        got_q.push_back(obs());
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1; n_total++;
        if (obs() !== 15'd0) $display("FAIL reset_outputs: got %h want %h", obs(), 15'd0);
        else n_pass++;
        n_total++;
        if (retired_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", retired_count);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0; instr_valid = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_addi();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,0,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 0, 0);
        exp_q.push_back(e(0,0,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 0, 0);
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 1, 0);
        // instr_valid stays high with a different word: must be ignored in EX0
        exp_q.push_back(e(1,0,1,0,0,0,0,1,0,0,0)); cyc(MOVZ, 1, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL addi[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL addi_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_dataimm();
        logic [14:0] ev, gv; int k;
        logic [31:0] ins [4] = '{32'h91001441, 32'hB1001441, 32'hF2000000, 32'hB2000000};
        logic        slv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0));      cyc(ins[i], 1, 0);
            exp_q.push_back(e(1,0,1,0,slv[i],0,0,1,0,0,0)); cyc(32'h0, 0, 0);
        end
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL dataimm[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
    endtask

    task automatic test_mov();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(MOVZ, 1, 0);
        exp_q.push_back(e(1,0,1,0,0,0,2,0,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(2,0,1,0,0,0,3,1,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(0,0,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL mov[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL mov_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [14:0] ev, gv; int k;
        logic [31:0] ins [4] = '{32'h14000000, 32'h94000000, 32'hB4000000, 32'h54000000};
        logic        rwv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  csv [4] = '{3'd4, 3'd4, 3'd5, 3'd5};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0));             cyc(ins[i], 1, 0);
            exp_q.push_back(e(1,0,rwv[i],0,0,0,csv[i],1,0,0,0));   cyc(32'h0, 0, 1);
        end
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL branch[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
    endtask

    task automatic test_datareg();
        logic [14:0] ev, gv; int k;
        logic [31:0] ins [4] = '{32'h8B000000, 32'hEB000000, 32'h8A000000, 32'hEA000000};
        logic        slv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0));      cyc(ins[i], 1, 0);
            exp_q.push_back(e(1,0,1,0,slv[i],0,0,1,0,0,0)); cyc(32'h0, 0, 0);
        end
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL datareg[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL datareg_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_mem_ready();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(LDUR, 1, 1);
        exp_q.push_back(e(1,0,1,0,0,1,6,1,0,0,0)); cyc(STUR, 0, 1);
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(STUR, 1, 1);
        exp_q.push_back(e(1,0,0,1,0,1,6,1,0,0,0)); cyc(LDUR, 0, 1);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL mem_ready[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
    endtask

    task automatic test_ldur_wait();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(LDUR, 1, 0);
        exp_q.push_back(e(1,0,0,0,0,1,6,0,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(4,0,0,0,0,1,6,0,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(4,0,0,0,0,1,6,0,0,0,0)); cyc(ADDI, 0, 0);
        exp_q.push_back(e(4,0,1,0,0,1,6,1,0,0,0)); cyc(ADDI, 0, 1);
        exp_q.push_back(e(0,0,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 0, 1);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL ldur_wait[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL ldur_wait_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
    endtask

    // Ready arriving in the 15th MEMWAIT cycle (the timeout cycle) must complete normally.
    task automatic test_ready_wins();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(STUR, 1, 0);
        exp_q.push_back(e(1,0,0,0,0,1,6,0,0,0,0)); cyc(STUR, 0, 0);
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(e(4,0,0,0,0,1,6,0,0,0,0)); cyc(STUR, 0, 0);
        end
        exp_q.push_back(e(4,0,0,1,0,1,6,1,0,0,0)); cyc(STUR, 0, 1);
        exp_q.push_back(e(0,0,0,0,0,0,0,0,0,0,0)); cyc(STUR, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL ready_wins[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
    endtask

    task automatic test_timeout();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(STUR, 1, 0);
        exp_q.push_back(e(1,0,0,0,0,1,6,0,0,0,0)); cyc(STUR, 0, 0);
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(e(4,0,0,0,0,1,6,0,0,0,0)); cyc(STUR, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e(7,0,0,0,0,0,0,0,0,1,1)); cyc(ADDI, 1, 1);
        end
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL timeout[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL timeout_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_illegal();
        logic [14:0] ev, gv; int k;
        logic [31:0] ins [3] = '{32'h00000000, 32'h9A000000, 32'hF8400400};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(ins[i], 1, 1);
            exp_q.push_back(e(1,0,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 1, 1);
            exp_q.push_back(e(7,0,0,0,0,0,0,0,1,0,1)); cyc(ADDI, 1, 1);
            exp_q.push_back(e(7,0,0,0,0,0,0,0,1,0,1)); cyc(LDUR, 1, 0);
            k = 0;
            while (exp_q.size() != 0) begin
                ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
                if (gv !== ev) $display("FAIL illegal%0d[%0d]: got %h want %h", i, k, gv, ev);
                else n_pass++;
                if (ev[3]) exp_cnt++;
                k++;
            end
            #1; n_total++;
            if (retired_count !== exp_cnt) $display("FAIL illegal%0d_count: got %0d want %0d", i, retired_count, exp_cnt);
            else n_pass++;
            do_reset();
        end
    endtask

    task automatic test_reset_mid_memwait();
        logic [14:0] ev, gv; int k;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(1,0,1,0,0,0,0,1,0,0,0)); cyc(ADDI, 0, 0);
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(LDUR, 1, 0);
        exp_q.push_back(e(1,0,0,0,0,1,6,0,0,0,0)); cyc(LDUR, 0, 0);
        exp_q.push_back(e(4,0,0,0,0,1,6,0,0,0,0)); cyc(LDUR, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL mid_reset_pre[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL mid_reset_pre_count: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
        // Assert reset between clock edges while still in MEMWAIT.
        #2; reset = 1'b1;
        #1; n_total++;
        if (obs() !== 15'd0) $display("FAIL mid_reset_outputs: got %h want %h", obs(), 15'd0);
        else n_pass++;
        n_total++;
        if (retired_count !== 4'd0) $display("FAIL mid_reset_count: got %0d want 0", retired_count);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_back_to_back();
        logic [14:0] ev, gv; int k;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 1, 0);
            exp_q.push_back(e(1,0,1,0,0,0,0,1,0,0,0)); cyc(ADDI, 1, 0);
        end
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL b2b[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== exp_cnt) $display("FAIL b2b_count15: got %0d want %0d", retired_count, exp_cnt);
        else n_pass++;
        exp_q.push_back(e(0,1,0,0,0,0,0,0,0,0,0)); cyc(ADDI, 1, 0);
        exp_q.push_back(e(1,0,1,0,0,0,0,1,0,0,0)); cyc(ADDI, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            ev = exp_q.pop_front(); gv = got_q.pop_front(); n_total++;
            if (gv !== ev) $display("FAIL b2b_last[%0d]: got %h want %h", k, gv, ev);
            else n_pass++;
            if (ev[3]) exp_cnt++;
            k++;
        end
        #1; n_total++;
        if (retired_count !== 4'd0) $display("FAIL b2b_wrap: got %0d want 0", retired_count);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        I           = ADDI;
        instr_valid = 1'b1;
        mem_ready   = 1'b1;
        status      = 5'b10101;
        test_reset();
        test_addi();
        test_dataimm();
        test_mov();
        test_branch();
        test_datareg();
        test_mem_ready();
        test_ldur_wait();
        test_ready_wins();
        test_timeout();
        test_illegal();
        test_reset_mid_memwait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
